serial_bus_slave: RTL

Bus-side target for the serial bus driven by the master. Deserialises the 16-bit address and 8-bit write data and returns address/write acknowledges on B_ACK. Serialises 8-bit read data back to the master. Holds a local byte memory selected by an address-ID field.

---
 rtl/serial_bus_slave_if.sv | 18 +
 rtl/serial_bus_slave.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_bus_slave_if.sv
// Serial bus signals shared between the bus master and a slave target.
interface serial_bus_slave_if;
  logic B_UTIL;     // master is in a bus phase
  logic B_RW;       // 1 = write, 0 = read
  logic B_BUS_IN;   // serial address / write data, LSB first
  logic B_BUS_OUT;  // serial read data, LSB first
  logic B_ACK;      // address / write acknowledge

  modport master (
    output B_UTIL, B_RW, B_BUS_IN,
    input  B_BUS_OUT, B_ACK
  );

  modport slave (
    input  B_UTIL, B_RW, B_BUS_IN,
    output B_BUS_OUT, B_ACK
  );
endinterface

// File: rtl/serial_bus_slave.sv
// Serial bus slave: deserialises a 16-bit address and an optional write byte,
// acknowledges on B_ACK, serialises read bytes back, and owns a local byte memory
// selected by the top address bits.
module serial_bus_slave #(
  parameter int                    ID_WIDTH    = 4,
  parameter logic [ID_WIDTH-1:0]   SLAVE_ID    = 4'd1,
  parameter int                    MEM_ADDR_W  = 11,
  parameter int                    ACKW_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  serial_bus_slave_if.slave     bus,
  output logic                  S_BSY,
  output logic                  S_WE,
  output logic [MEM_ADDR_W-1:0] S_WADDR,
  output logic [7:0]            S_WDATA
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    ACK_A = 3'd2,
    WDATA = 3'd3,
    ACK_W = 3'd4,
    RDATA = 3'd5,
    SKIP  = 3'd6
  } state_t;

  localparam logic [3:0] ACKW_LAST = 4'(ACKW_CYCLES - 1);

  state_t                  state_reg, state_next;
  logic [3:0]              count_reg, count_next;
  logic [15:0]             addr_reg;
  logic                    rw_reg;
  logic [7:0]              wdata_reg;
  logic [7:0]              rd_data_reg;
  logic                    we_reg;
  logic [MEM_ADDR_W-1:0]   waddr_reg;
  logic [7:0]              wbyte_reg;

  logic [7:0]              mem [2**MEM_ADDR_W];

  logic [15:0]             addr_full;
  logic                    id_match;
  logic [MEM_ADDR_W-1:0]   mem_idx;
  logic                    commit;
  logic [7:0]              commit_byte;
  logic                    unused_bits;

  // The ID is checked on the same edge that samples addr[15], so the top bit
  // comes straight from the bus rather than from the shift register.
  assign addr_full   = {bus.B_BUS_IN, addr_reg[14:0]};
  assign id_match    = (addr_full[15 -: ID_WIDTH] == SLAVE_ID);
  assign mem_idx     = addr_reg[MEM_ADDR_W-1:0];
  assign commit      = (state_reg == WDATA) && bus.B_UTIL && (count_reg == 4'd7);
  assign commit_byte = {bus.B_BUS_IN, wdata_reg[6:0]};
  // Address bits between the index and the ID field carry no meaning here.
  assign unused_bits = ^{addr_reg, wdata_reg[7]};

  assign S_BSY         = (state_reg != IDLE);
  assign S_WE          = we_reg;
  assign S_WADDR       = waddr_reg;
  assign S_WDATA       = wbyte_reg;
  assign bus.B_ACK     = (state_reg == ACK_A) || (state_reg == ACK_W);
  assign bus.B_BUS_OUT = (state_reg == RDATA) ? rd_data_reg[count_reg[2:0]] : 1'b0;

  // State and bit counter register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic; the counter restarts on every state change.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg + 4'd1;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (bus.B_UTIL) begin
          state_next = ADDR;
          count_next = 4'd1;
        end
      end
      ADDR: begin
        if (!bus.B_UTIL) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count_reg == 4'd15) begin
          state_next = id_match ? ACK_A : SKIP;
          count_next = '0;
        end
      end
      ACK_A: begin
        state_next = rw_reg ? WDATA : RDATA;
        count_next = '0;
      end
      WDATA: begin
        if (!bus.B_UTIL) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count_reg == 4'd7) begin
          state_next = ACK_W;
          count_next = '0;
        end
      end
      ACK_W: begin
        if (count_reg == ACKW_LAST) begin
          state_next = IDLE;
          count_next = '0;
        end
      end
      RDATA: begin
        if (count_reg == 4'd7) begin
          state_next = IDLE;
          count_next = '0;
        end
      end
      SKIP: begin
        count_next = '0;
        if (!bus.B_UTIL) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Address/data shift registers, read-byte load and write-commit strobe.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      addr_reg    <= '0;
      rw_reg      <= 1'b0;
      wdata_reg   <= '0;
      rd_data_reg <= '0;
      we_reg      <= 1'b0;
      waddr_reg   <= '0;
      wbyte_reg   <= '0;
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.B_UTIL) begin
            addr_reg <= {15'd0, bus.B_BUS_IN};
            rw_reg   <= bus.B_RW;
          end
        end
        ADDR: begin
          if (bus.B_UTIL) addr_reg[count_reg] <= bus.B_BUS_IN;
        end
        ACK_A: begin
          if (!rw_reg) rd_data_reg <= mem[mem_idx];
        end
        WDATA: begin
          if (bus.B_UTIL) wdata_reg[count_reg[2:0]] <= bus.B_BUS_IN;
          if (commit) begin
            we_reg    <= 1'b1;
            waddr_reg <= mem_idx;
            wbyte_reg <= commit_byte;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte memory write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (commit) mem[mem_idx] <= commit_byte;
  end

endmodule
